// File: rtl/dm_access_ctrl.sv
// Load/store controller in front of the word-organised DM_4k data memory.
// Handles byte/half/word accesses with alignment checks, little-endian lane
// selection, sign/zero extension, and read-modify-write for sub-word stores.
module dm_access_ctrl #(
  parameter int unsigned DM_AW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  output logic             dm_we,
  input  logic [31:0]      dm_dout
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRmwRd,
    StWr,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Request fields captured at acceptance; only the bits the datapath uses.
  logic [DM_AW+1:0] addr_q;
  logic [15:0]      wdata_q;
  logic [1:0]       size_q;
  logic             signed_q;

  logic             resp_valid_q;
  logic             resp_err_q;
  logic [31:0]      resp_rdata_q;
  logic [31:0]      dm_din_q;

  logic             accept;
  logic             req_err;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;
  logic [31:0]      merge_data;

  assign accept = req_valid & req_ready;

  // Reject reserved sizes, misaligned accesses and addresses outside the 4 KiB window.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if ((req_size == 2'b01) && req_addr[0]) req_err = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (|req_addr[31:DM_AW+2]) req_err = 1'b1;
  end

  // Lane extraction and extension for loads.
  always_comb begin
    byte_sel  = dm_dout[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = dm_dout[{addr_q[1], 4'b0000} +: 16];
    load_data = dm_dout;
    case (size_q)
      2'b00:   load_data = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      2'b01:   load_data = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      default: load_data = dm_dout;
    endcase
  end

  // Merge store data into the word read back, keeping untouched lanes.
  always_comb begin
    merge_data = dm_dout;
    if (size_q == 2'b00) begin
      merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  // Next-state decode and handshake ready.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                 state_d = StResp;
          else if (!req_wr)            state_d = StRd;
          else if (req_size == 2'b10)  state_d = StWr;
          else                         state_d = StRmwRd;
        end
      end
      StRd:    state_d = StResp;
      StRmwRd: state_d = StWr;
      StWr:    state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Request capture, response registers and write-data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      dm_din_q     <= '0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr[DM_AW+1:0];
        wdata_q  <= req_wdata[15:0];
        size_q   <= req_size;
        signed_q <= req_signed;
        if (req_err) begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_rdata_q <= '0;
        end else if (req_wr && (req_size == 2'b10)) begin
          dm_din_q <= req_wdata;
        end
      end
      if (state_q == StRd) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= load_data;
      end
      if (state_q == StRmwRd) dm_din_q <= merge_data;
      if (state_q == StWr) resp_valid_q <= 1'b1;
      if ((state_q == StResp) && resp_ready) begin
        resp_valid_q <= 1'b0;
        resp_err_q   <= 1'b0;
        resp_rdata_q <= '0;
      end
    end
  end

  // Memory port drive; write enable gated by reset so an abandoned write never lands.
  always_comb begin
    dm_addr = '0;
    if ((state_q == StRd) || (state_q == StRmwRd) || (state_q == StWr)) begin
      dm_addr = addr_q[DM_AW+1:2];
    end
    dm_we = (state_q == StWr) && rst_n;
  end

  assign dm_din     = dm_din_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural DM_4k model.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;

  logic [31:0] mem [1024];
  int          we_cnt = 0;
  logic [9:0]  we_addr;
  int          total = 0;
  int          bad = 0;

  dm_access_ctrl #(.DM_AW(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dm_addr    (dm_addr),
    .dm_din     (dm_din),
    .dm_we      (dm_we),
    .dm_dout    (dm_dout)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the clock edge.
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) begin
    if (dm_we) begin
      mem[dm_addr] <= dm_din;
      we_cnt       <= we_cnt + 1;
      we_addr      <= dm_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One full transaction; lat counts clock edges from acceptance to resp_valid.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          w0;
    logic [31:0] hold;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[2] = 32'h1122_3344;

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_din", dm_din, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_req_ready", req_ready, 1);

    // Word store then word load.
    w0 = we_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h0000_0020, rd, er, lat);
    chk("wst_err", er, 0);
    chk("wst_lat", lat, 2);
    chk("wst_we_pulses", we_cnt - w0, 1);
    chk("wst_we_addr", we_addr, 1);
    chk("wst_mem1", mem[1], 32'h0000_0020);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, er, lat);
    chk("wld_data", rd, 32'h0000_0020);
    chk("wld_err", er, 0);
    chk("wld_lat", lat, 2);

    // Byte store via read-modify-write.
    w0 = we_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AB, rd, er, lat);
    chk("bst_lat", lat, 3);
    chk("bst_err", er, 0);
    chk("bst_we_pulses", we_cnt - w0, 1);
    chk("bst_mem2", mem[2], 32'h1122_AB44);

    // Load extension on 0x1122AB44.
    do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, rd, er, lat);
    chk("ld_sb9", rd, 32'hFFFF_FFAB);
    do_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, rd, er, lat);
    chk("ld_ub9", rd, 32'h0000_00AB);
    do_req(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, rd, er, lat);
    chk("ld_sha", rd, 32'h0000_1122);
    do_req(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, rd, er, lat);
    chk("ld_sh8", rd, 32'hFFFF_AB44);
    chk("ld_sh8_lat", lat, 2);

    // Half store into the upper lane of word 1.
    do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234_BEEF, rd, er, lat);
    chk("hst_lat", lat, 3);
    chk("hst_mem1", mem[1], 32'hBEEF_0020);

    // Error cases: no write, zero data, one-cycle latency.
    w0 = we_cnt;
    do_req(1'b0, 2'b01, 1'b1, 32'h5, 32'h0, rd, er, lat);
    chk("err_h5_err", er, 1);
    chk("err_h5_data", rd, 0);
    chk("err_h5_lat", lat, 1);
    do_req(1'b1, 2'b10, 1'b0, 32'h6, 32'hDEAD_BEEF, rd, er, lat);
    chk("err_w6_err", er, 1);
    chk("err_w6_data", rd, 0);
    do_req(1'b1, 2'b11, 1'b0, 32'h8, 32'hDEAD_BEEF, rd, er, lat);
    chk("err_sz3_err", er, 1);
    chk("err_sz3_data", rd, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEAD_BEEF, rd, er, lat);
    chk("err_oob_err", er, 1);
    chk("err_oob_data", rd, 0);
    chk("err_oob_lat", lat, 1);
    chk("err_no_we", we_cnt - w0, 0);
    chk("err_mem1", mem[1], 32'hBEEF_0020);
    chk("err_mem2", mem[2], 32'h1122_AB44);
    chk("err_mem0", mem[0], 32'h0);

    // Backpressure with a second request waiting.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h8;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid", resp_valid, 1);
    chk("bp_data", resp_rdata, 32'h1122_AB44);
    hold = resp_rdata;
    req_valid = 1'b1; req_addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_data", resp_rdata, 32'h1122_AB44);
      chk("bp_hold_err", resp_err, 0);
      chk("bp_hold_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_cleared", resp_valid, 0);
    chk("bp_ready_after", req_ready, 1);
    @(negedge clk);
    chk("bp_second_taken", req_ready, 0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", resp_valid, 1);
    chk("bp_second_data", resp_rdata, 32'hBEEF_0020);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset during RMW_RD of a byte store to word 2.
    w0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b00; req_addr = 32'h8; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_dm_addr", dm_addr, 2);
    chk("rmw_no_we", dm_we, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", dm_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_pulses", we_cnt - w0, 0);
    chk("rst_mid_mem2", mem[2], 32'h1122_AB44);
    chk("rst_mid_valid", resp_valid, 0);
    chk("rst_mid_err", resp_err, 0);
    chk("rst_mid_rdata", resp_rdata, 0);
    chk("rst_mid_dm_addr", dm_addr, 0);
    chk("rst_mid_dm_din", dm_din, 0);
    chk("rst_mid_ready", req_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator-side load/store controller that drives the word-organised data memory DM_4k port (addr[11:2], din, we, dout).
- Accepts byte/halfword/word load and store requests from the CPU pipeline over a valid/ready handshake.
- Performs alignment checks, little-endian lane selection and sign/zero extension.
- Implements sub-word stores as read-modify-write, because the memory only writes whole words.

Parameters:
- DM_AW, 10, word-address width of the data memory (1024 words = 4 KiB); dm_addr spans [DM_AW+1:2].

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data; right-aligned for sub-word sizes
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected, no memory write issued
- dm_addr  out  DM_AW  word address to DM_4k
- dm_din  out  32  write data to DM_4k
- dm_we  out  1  write enable to DM_4k
- dm_dout  in  32  read data from DM_4k; combinational for the presented dm_addr

Behaviour:
- States: IDLE, RD, RMW_RD, WR, RESP.
- Reset (rst_n low at a clock edge):
  - Next state is IDLE.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0, dm_addr = 0, dm_din = 0.
  - dm_we is gated to 0 combinationally whenever rst_n = 0, so a reset arriving in WR never writes.
  - Reset mid-operation abandons the request with no response.
- IDLE:
  - req_ready = 1; acceptance is req_valid & req_ready.
  - On acceptance, latch addr, wdata, size, wr and signed.
  - Error if any of: req_size = 11; half with addr[0] = 1; word with addr[1:0] != 00; addr[31:DM_AW+2] != 0. An error goes to RESP with resp_err = 1.
  - Otherwise: load goes to RD; word store goes to WR; byte or half store goes to RMW_RD.
- req_ready = 0 in every state other than IDLE; there is exactly one outstanding request.
- dm_addr = latched addr[DM_AW+1:2] in RD, RMW_RD and WR.
- RD:
  - Select the lane from dm_dout: byte lane = addr[1:0], half lane = addr[1].
  - Extend per req_signed into resp_rdata, then go to RESP.
- RMW_RD:
  - Merge dm_dout with the store data at byte lane addr[1:0] (or half lane addr[1]); all other lanes are kept.
  - Register the merged word into dm_din, then go to WR.
- WR:
  - dm_we = 1 for exactly this one cycle; dm_din = merged word, or req_wdata for word stores.
  - The write takes effect at the clock edge leaving WR. Then go to RESP.
- RESP:
  - resp_valid = 1; outputs are held stable until resp_ready = 1.
  - On the handshake edge, go to IDLE and clear resp_valid, resp_err and resp_rdata.
- Latency from the accept edge to resp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- resp_ready is ignored outside RESP. dm_we is never asserted in any state except WR.

Test Plan:
- Word store, then word load: store addr 0x4, data 0x00000020; then load addr 0x4.
  - -> dm_we high exactly 1 cycle with dm_addr = 1.
  - -> load returns resp_rdata = 0x00000020, resp_err = 0, resp_valid 2 cycles after accept.
- Byte store read-modify-write: word 2 preloaded with 0x11223344; store byte 0xAB at addr 0x9.
  - -> sequence RMW_RD, WR; memory word 2 = 0x1122AB44; resp_valid 3 cycles after accept.
- Load extension on word 2 = 0x1122AB44:
  - -> signed byte at 0x9 gives 0xFFFFFFAB.
  - -> unsigned byte at 0x9 gives 0x000000AB.
  - -> signed half at 0xA gives 0x00001122.
  - -> signed half at 0x8 gives 0xFFFFAB44.
- Errors:
  - -> half at 0x5, word at 0x6, size 11, and word at 0x1000 each give resp_err = 1 and resp_rdata = 0.
  - -> dm_we never rises and memory is unchanged.
- Backpressure: hold resp_ready = 0 for 3 cycles after resp_valid, with a second req_valid pending.
  - -> resp fields stay stable and req_ready stays 0.
  - -> the second request is accepted only in the cycle after the handshake.
- Reset mid-operation: assert rst_n = 0 in the RMW_RD cycle of a byte store to word 2.
  - -> no dm_we pulse and word 2 unchanged.
  - -> all outputs zero, state IDLE, and req_ready = 1 after release.
